// File: rtl/fetch_buffered_if.sv
// Fetch unit bus: redirect inputs, decoder-side queue head, and I-cache
// request/response handshake.
interface fetch_buffered_if;
  logic        clear;
  logic [31:0] new_pc;
  logic        clear_decoder;
  logic [31:0] new_pc_decoder;
  logic        need_inst;
  logic        inst_ready_out;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        fetch_ready_in;
  logic [31:0] output_next_PC;
  logic [31:0] inst_in;
  logic        instcache_ready_out;

  // fetch unit side
  modport master (
    input  clear, new_pc, clear_decoder, new_pc_decoder, need_inst,
           inst_in, instcache_ready_out,
    output inst_ready_out, inst, inst_addr, fetch_ready_in, output_next_PC
  );

  // environment side (decoder, ROB, I-cache)
  modport slave (
    output clear, new_pc, clear_decoder, new_pc_decoder, need_inst,
           inst_in, instcache_ready_out,
    input  inst_ready_out, inst, inst_addr, fetch_ready_in, output_next_PC
  );
endinterface

// File: rtl/fetch_buffered.sv
// Buffered instruction fetch: one outstanding I-cache request at a time,
// responses land in a small circular queue read by the decoder. A redirect
// flushes the queue; a response to a request issued before the redirect is
// swallowed via the discard flag. Optional halt after control-flow opcodes.
module fetch_buffered #(
  parameter int          QUEUE_LOG2   = 2,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          BRANCH_STALL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  fetch_buffered_if.master bus
);
  localparam int DEPTH = 1 << QUEUE_LOG2;
  localparam logic [QUEUE_LOG2-1:0] PTR_ONE = 1;
  localparam logic [QUEUE_LOG2:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_t;

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [QUEUE_LOG2-1:0] head_q, head_d, tail_q, tail_d;
  logic [QUEUE_LOG2:0]   count_q, count_d;
  logic                  discard_q, discard_d;
  logic                  req_q, req_d;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] addr_mem [DEPTH];

  logic redirect, push, pop, is_cf, full;

  // next-state: FSM, pc, queue pointers; everything holds while rdy is low
  always_comb begin
    redirect  = bus.clear | bus.clear_decoder;
    full      = count_q[QUEUE_LOG2];  // count never exceeds DEPTH
    pop       = rdy && bus.need_inst && (count_q != '0) && !redirect;
    is_cf     = (bus.inst_in[6:0] == 7'b1101111) ||
                (bus.inst_in[6:0] == 7'b1100111) ||
                (bus.inst_in[6:0] == 7'b1100011);
    push      = rdy && (state_q == S_WAIT) && bus.instcache_ready_out &&
                !discard_q && !redirect;
    state_d   = state_q;
    pc_d      = pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    discard_d = discard_q;
    req_d     = req_q;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          // no request on a redirect cycle: pc is about to change
          if (!redirect && !full) begin
            state_d = S_WAIT;
            req_d   = 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.instcache_ready_out) begin
            req_d     = 1'b0;
            discard_d = 1'b0;
            if (discard_q || redirect) begin
              state_d = S_IDLE;
            end else begin
              pc_d    = pc_q + 32'd4;
              state_d = ((BRANCH_STALL != 0) && is_cf) ? S_HALT : S_IDLE;
            end
          end else if (redirect) begin
            // stale request still in flight; swallow its response later
            discard_d = 1'b1;
            req_d     = 1'b0;
          end
        end
        S_HALT: begin
          if (redirect) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (redirect) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        pc_d    = bus.clear ? bus.new_pc : bus.new_pc_decoder;
      end else begin
        if (push) tail_d = tail_q + PTR_ONE;
        if (pop)  head_d = head_q + PTR_ONE;
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
      end
    end
  end

  // control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      req_q     <= req_d;
    end
  end

  // queue storage; contents are don't-care until counted in
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= bus.inst_in;
      addr_mem[tail_q] <= pc_q;
    end
  end

  // outputs; head is gated to zero when empty so reset shows zeros
  always_comb begin
    bus.fetch_ready_in = req_q;
    bus.output_next_PC = pc_q;
    bus.inst_ready_out = (count_q != '0);
    bus.inst           = bus.inst_ready_out ? inst_mem[head_q] : 32'h0;
    bus.inst_addr      = bus.inst_ready_out ? addr_mem[head_q] : 32'h0;
  end
endmodule

// File: tb/tb_fetch_buffered.sv
// Bench for fetch_buffered: directed stimulus drives the cache and redirect
// inputs; a scoreboard queue holds expected queue entries and an independent
// monitor compares every decoder pop against it.
module tb_fetch_buffered;
  logic clk, rst, rdy;
  fetch_buffered_if bus();

  fetch_buffered #(.QUEUE_LOG2(2), .RESET_PC(32'h0), .BRANCH_STALL(1)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  ent_t sb[$];
  int   tests = 0;
  int   fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // wait (bounded) for a cache request and check its address
  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!bus.fetch_ready_in && n < 30) begin
      tick();
      n++;
    end
    check("req_valid", {31'd0, bus.fetch_ready_in}, 32'd1);
    check("req_addr", bus.output_next_PC, a);
  endtask

  // answer the pending request; expected entry recorded if it should be queued
  task automatic respond(input logic [31:0] data, input bit push, input logic [31:0] a);
    wait_req(a);
    bus.inst_in = data;
    bus.instcache_ready_out = 1'b1;
    if (push) sb.push_back({data, a});
    tick();
    bus.instcache_ready_out = 1'b0;
  endtask

  task automatic pulse_resp(input logic [31:0] data);
    bus.inst_in = data;
    bus.instcache_ready_out = 1'b1;
    tick();
    bus.instcache_ready_out = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // monitor: compare every accepted pop against the scoreboard head
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rdy && bus.need_inst && bus.inst_ready_out &&
          !bus.clear && !bus.clear_decoder) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got %h@%h expected no entry", bus.inst, bus.inst_addr);
        end else begin
          e = sb.pop_front();
          check("pop_inst", bus.inst, e.inst);
          check("pop_addr", bus.inst_addr, e.addr);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.clear = 1'b0;
    bus.new_pc = 32'h0;
    bus.clear_decoder = 1'b0;
    bus.new_pc_decoder = 32'h0;
    bus.need_inst = 1'b0;
    bus.inst_in = 32'h0;
    bus.instcache_ready_out = 1'b0;
    tick();
    // reset state
    check("rst_ready_out", {31'd0, bus.inst_ready_out}, 32'd0);
    check("rst_fetch", {31'd0, bus.fetch_ready_in}, 32'd0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_addr", bus.inst_addr, 32'h0);
    check("rst_next_pc", bus.output_next_PC, 32'h0);
    tick();
    rst = 1'b0;

    // sequential fill to DEPTH=4
    for (int i = 0; i < 4; i++) respond(32'h00000013, 1'b1, 32'(i * 4));
    repeat (4) tick();
    check("full_no_req", {31'd0, bus.fetch_ready_in}, 32'd0);
    check("full_ready", {31'd0, bus.inst_ready_out}, 32'd1);
    check("full_head_inst", bus.inst, 32'h00000013);
    check("full_head_addr", bus.inst_addr, 32'h0);

    // one pop frees a slot -> request at 0x10, back to full after response
    bus.need_inst = 1'b1;
    tick();
    bus.need_inst = 1'b0;
    respond(32'h00000013, 1'b1, 32'h10);
    repeat (3) tick();
    check("refull_no_req", {31'd0, bus.fetch_ready_in}, 32'd0);
    check("refull_head_addr", bus.inst_addr, 32'h4);
    // drain, plus one extra pop while empty (no-op)
    bus.need_inst = 1'b1;
    repeat (5) tick();
    bus.need_inst = 1'b0;
    check("drain_empty", {31'd0, bus.inst_ready_out}, 32'd0);
    check("drain_sb_empty", sb.size(), 32'd0);

    // branch stall
    do_reset();
    respond(32'h00000013, 1'b1, 32'h0);
    respond(32'h00000013, 1'b1, 32'h4);
    respond(32'h0000006F, 1'b1, 32'h8);
    repeat (4) tick();
    check("halt_no_req", {31'd0, bus.fetch_ready_in}, 32'd0);
    check("halt_ready", {31'd0, bus.inst_ready_out}, 32'd1);
    bus.need_inst = 1'b1;
    tick();
    bus.need_inst = 1'b0;
    repeat (2) tick();
    check("halt_drain_no_req", {31'd0, bus.fetch_ready_in}, 32'd0);
    check("halt_drain_head", bus.inst_addr, 32'h4);
    bus.clear_decoder = 1'b1;
    bus.new_pc_decoder = 32'h100;
    sb.delete();
    tick();
    bus.clear_decoder = 1'b0;
    check("redir_flush", {31'd0, bus.inst_ready_out}, 32'd0);
    respond(32'h00000013, 1'b1, 32'h100);
    bus.need_inst = 1'b1;
    tick();
    bus.need_inst = 1'b0;

    // redirect while waiting: response dropped
    do_reset();
    respond(32'h00000013, 1'b1, 32'h0);
    wait_req(32'h4);
    bus.clear = 1'b1;
    bus.new_pc = 32'h200;
    sb.delete();
    tick();
    bus.clear = 1'b0;
    check("disc_no_req", {31'd0, bus.fetch_ready_in}, 32'd0);
    check("disc_flush", {31'd0, bus.inst_ready_out}, 32'd0);
    repeat (2) tick();
    check("disc_blocked", {31'd0, bus.fetch_ready_in}, 32'd0);
    pulse_resp(32'h00000013);
    check("disc_dropped", {31'd0, bus.inst_ready_out}, 32'd0);
    wait_req(32'h200);

    // redirect in the same cycle as the response
    bus.clear_decoder = 1'b1;
    bus.new_pc_decoder = 32'h300;
    bus.inst_in = 32'h00000013;
    bus.instcache_ready_out = 1'b1;
    tick();
    bus.clear_decoder = 1'b0;
    bus.instcache_ready_out = 1'b0;
    check("same_cyc_dropped", {31'd0, bus.inst_ready_out}, 32'd0);
    wait_req(32'h300);

    // simultaneous redirects: clear wins
    bus.clear = 1'b1;
    bus.new_pc = 32'h40;
    bus.clear_decoder = 1'b1;
    bus.new_pc_decoder = 32'h80;
    tick();
    bus.clear = 1'b0;
    bus.clear_decoder = 1'b0;
    pulse_resp(32'h00000013);
    wait_req(32'h40);

    // rdy low: response pulse ignored, state held
    rdy = 1'b0;
    pulse_resp(32'h00000013);
    repeat (4) tick();
    check("rdy_hold_req", {31'd0, bus.fetch_ready_in}, 32'd1);
    check("rdy_hold_pc", bus.output_next_PC, 32'h40);
    check("rdy_no_push", {31'd0, bus.inst_ready_out}, 32'd0);
    rdy = 1'b1;
    respond(32'h00000013, 1'b1, 32'h40);
    check("rdy_after_push", {31'd0, bus.inst_ready_out}, 32'd1);
    check("rdy_after_addr", bus.inst_addr, 32'h40);
    wait_req(32'h44);

    // asynchronous reset mid-WAIT
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check("arst_fetch", {31'd0, bus.fetch_ready_in}, 32'd0);
    check("arst_ready_out", {31'd0, bus.inst_ready_out}, 32'd0);
    check("arst_inst", bus.inst, 32'h0);
    check("arst_inst_addr", bus.inst_addr, 32'h0);
    check("arst_next_pc", bus.output_next_PC, 32'h0);
    tick();
    rst = 1'b0;
    wait_req(32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_buffered.md
FETCH_BUFFERED -- requirements
Module: fetch_buffered

Interface
REQ-001 SHALL have parameter QUEUE_LOG2, default 2, meaning queue depth DEPTH = 2^QUEUE_LOG2 entries.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-003 SHALL have parameter BRANCH_STALL, default 1, meaning fetch halts after enqueuing a control-flow instruction (opcode 1101111, 1100111 or 1100011) until a redirect.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port rdy, input, 1 bit: global enable; when low, all state holds and all inputs are ignored.
REQ-007 SHALL have port clear, input, 1 bit: ROB redirect request.
REQ-008 SHALL have port new_pc, input, 32 bits: ROB redirect target.
REQ-009 SHALL have port clear_decoder, input, 1 bit: decoder redirect request.
REQ-010 SHALL have port new_pc_decoder, input, 32 bits: decoder redirect target.
REQ-011 SHALL have port need_inst, input, 1 bit: decoder pops the queue head this cycle.
REQ-012 SHALL have port inst_ready_out, output, 1 bit: queue non-empty.
REQ-013 SHALL have port inst, output, 32 bits: instruction at the queue head.
REQ-014 SHALL have port inst_addr, output, 32 bits: PC of the queue head.
REQ-015 SHALL have port fetch_ready_in, output, 1 bit: cache request valid.
REQ-016 SHALL have port output_next_PC, output, 32 bits: cache request address.
REQ-017 SHALL have port inst_in, input, 32 bits: cache response data.
REQ-018 SHALL have port instcache_ready_out, input, 1 bit: one-cycle cache response pulse.

Function
REQ-019 SHALL implement a 3-state FSM: IDLE (no request outstanding), WAIT (request outstanding), HALT (BRANCH_STALL hold).
REQ-020 SHALL in IDLE assert fetch_ready_in with output_next_PC = pc when occupancy < DEPTH, and enter WAIT; SHALL deassert it otherwise.
REQ-021 SHALL in WAIT hold fetch_ready_in high and output_next_PC stable until instcache_ready_out is seen, then drop fetch_ready_in on the next cycle, with at most one request outstanding.
REQ-022 SHALL on a response in WAIT with no discard pending push {inst_in, pc} at the tail and set pc <= pc+4 (mod 2^32); the next state is HALT if BRANCH_STALL=1 and inst_in[6:0] is a control-flow opcode, else IDLE.
REQ-023 SHALL expose the head entry on inst and inst_addr combinationally from storage, with inst_ready_out = (count != 0).
REQ-024 SHALL pop the head when need_inst && inst_ready_out; need_inst while empty SHALL be a no-op.
REQ-025 SHALL leave count unchanged on a simultaneous push and pop; push while full cannot occur (guaranteed by REQ-020); pointers SHALL be QUEUE_LOG2 bits and wrap modulo DEPTH.
REQ-026 SHALL on a redirect (clear or clear_decoder) empty the queue (pointers and count to 0) and load pc from new_pc if clear is set, else from new_pc_decoder; clear has priority; a redirect overrides any same-cycle push or pop.
REQ-027 SHALL, if a redirect arrives in WAIT before the response, set discard pending, drop fetch_ready_in and stay blocked; the next instcache_ready_out SHALL be dropped and clear discard pending, after which the FSM enters IDLE.
REQ-028 SHALL treat a redirect in the same cycle as the response as case REQ-027 with the response discarded, so there is no push and the FSM goes to IDLE.
REQ-029 SHALL leave HALT only on a redirect, going to IDLE; the queue SHALL continue to drain via pops while in HALT.
REQ-030 SHALL use a fetch-to-queue latency of 1 cycle after instcache_ready_out, so that the entry is visible on inst_ready_out the following cycle.

Reset
REQ-031 SHALL on rst high asynchronously set: state IDLE, pc = RESET_PC, count and pointers 0, discard pending 0, inst_ready_out 0, fetch_ready_in 0, inst 0, inst_addr 0, output_next_PC = RESET_PC.
REQ-032 SHALL treat reset mid-transaction as abandoning any outstanding request; the first request after deassertion uses RESET_PC.

Verification
REQ-033 SHALL test sequential fill: cache returns 32'h00000013 every request with need_inst=0 and DEPTH=4 -> exactly 4 entries at PCs 0,4,8,C, then fetch_ready_in stays 0.
REQ-034 SHALL test pop/push overlap: with the queue at 4 entries, need_inst=1 for one cycle -> a new request is issued at PC 10, and count returns to 4 after its response.
REQ-035 SHALL test branch stall: response 32'h0000006F at PC 8 with BRANCH_STALL=1 -> FSM enters HALT with no further requests; clear_decoder=1 with new_pc_decoder=32'h100 -> queue is empty and the next request is at 32'h100.
REQ-036 SHALL test redirect during WAIT: clear=1 with new_pc=32'h200 while a request at 32'h4 is pending -> that response is dropped (inst_ready_out stays 0) and the next request is at 32'h200.
REQ-037 SHALL test simultaneous redirect: clear=1 (new_pc=32'h40) and clear_decoder=1 (new_pc_decoder=32'h80) in the same cycle -> the next request is at 32'h40.
REQ-038 SHALL test rdy/reset: rdy=0 for 5 cycles with a response pulse -> no state change; rst asserted mid-WAIT -> outputs take their reset values immediately, without waiting for a clock edge.
